// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives a word-addressed instruction memory with a
// req/ready handshake, registers fetched words for the IF/ID buffer, absorbs
// one word in a skid entry under stall, and handles branch redirects that
// arrive while a request is still outstanding.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_if,
  output logic        instr_valid
);

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } skid_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] instr_d, pc_if_d;
  logic        valid_d;
  skid_t       skid, skid_d;
  logic        redirect_pending, rp_d;
  logic [31:0] redirect_pc, rpc_d;

  logic xfer, flush;

  // Only REQ presents a request; the address is the fetch pc and stays put
  // while the request waits, since pc only moves on a transfer or out of REQ.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign xfer      = imem_req && imem_ready;
  assign flush     = branch_taken || redirect_pending;

  // Next-state and datapath selection; redirects take priority over stall.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instr;
    pc_if_d = pc_if;
    valid_d = instr_valid;
    skid_d  = skid;
    rp_d    = redirect_pending;
    rpc_d   = redirect_pc;
    case (state)
      IDLE: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          state_d = stall ? IDLE : REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (xfer) begin
          if (flush) begin
            // Word belongs to the wrong path: drop it and restart at the target.
            // A branch on this same edge is newer than any pending redirect.
            pc_d    = branch_taken ? branch_target : redirect_pc;
            rp_d    = 1'b0;
            valid_d = 1'b0;
          end else if (stall) begin
            skid_d  = '{word: imem_rdata, pc: pc};
            pc_d    = pc + PC_STEP;
            state_d = FULL;
          end else begin
            instr_d = imem_rdata;
            pc_if_d = pc;
            valid_d = 1'b1;
            pc_d    = pc + PC_STEP;
          end
        end else begin
          // Request in flight: the address must not move, so remember the
          // redirect until the outstanding word comes back.
          if (branch_taken) begin
            rp_d  = 1'b1;
            rpc_d = branch_target;
          end
          if (flush || !stall) valid_d = 1'b0;
        end
      end
      FULL: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          skid_d  = '0;
          valid_d = 1'b0;
          state_d = stall ? IDLE : REQ;
        end else if (!stall) begin
          instr_d = skid.word;
          pc_if_d = skid.pc;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      instr            <= '0;
      pc_if            <= '0;
      instr_valid      <= 1'b0;
      skid             <= '0;
      redirect_pending <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      state            <= state_d;
      pc               <= pc_d;
      instr            <= instr_d;
      pc_if            <= pc_if_d;
      instr_valid      <= valid_d;
      skid             <= skid_d;
      redirect_pending <= rp_d;
      redirect_pc      <= rpc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model built from queues.
module tb_if_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_if;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Memory contents: each word is its address plus 0x100.
  assign imem_rdata = imem_addr + 32'h100;

  if_fetch_stage dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .pc_if        (pc_if),
    .instr_valid  (instr_valid)
  );

  // Model: "running" says the stage wants to fetch; a non-empty held queue
  // is the one buffered word; redir holds a remembered redirect target.
  logic        m_running;
  logic [31:0] m_fetch_pc;
  logic [63:0] m_held[$];
  logic [31:0] m_redir[$];
  logic [31:0] m_instr, m_pc_if;
  logic        m_valid;

  function automatic logic m_req();
    return m_running && (m_held.size() == 0);
  endfunction

  task automatic model_reset();
    m_running  = 1'b0;
    m_fetch_pc = 32'h0;
    m_held.delete();
    m_redir.delete();
    m_instr    = 32'h0;
    m_pc_if    = 32'h0;
    m_valid    = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] p);
    m_instr = w;
    m_pc_if = p;
    m_valid = 1'b1;
  endtask

  task automatic model_step();
    logic [63:0] h;
    logic        got;
    got = m_req() && imem_ready;
    if (reset) begin
      model_reset();
    end else if (!m_req()) begin
      // Not fetching: either idle or holding a buffered word.
      if (branch_taken) begin
        m_fetch_pc = branch_target;
        m_held.delete();
        m_valid    = 1'b0;
        m_running  = !stall;
      end else if (m_held.size() != 0) begin
        if (!stall) begin
          h = m_held.pop_front();
          deliver(h[63:32], h[31:0]);
        end
      end else if (!stall) begin
        m_running = 1'b1;
        m_valid   = 1'b0;
      end
    end else if (got) begin
      if (branch_taken || m_redir.size() != 0) begin
        m_fetch_pc = branch_taken ? branch_target : m_redir[0];
        m_redir.delete();
        m_valid    = 1'b0;
      end else begin
        if (stall) m_held.push_back({m_fetch_pc + 32'h100, m_fetch_pc});
        else       deliver(m_fetch_pc + 32'h100, m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd1;
      end
    end else begin
      if (branch_taken) begin
        m_redir.delete();
        m_redir.push_back(branch_target);
      end
      if (branch_taken || m_redir.size() != 0 || !stall) m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) chk("imem_addr", imem_addr, m_fetch_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("pc_if", pc_if, m_pc_if);
    chk("instr", instr, m_instr);
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic s, input logic r, input logic b, input logic [31:0] t);
    stall         = s;
    imem_ready    = r;
    branch_taken  = b;
    branch_target = t;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    model_reset();

    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    reset = 1'b0;

    // Streaming: first valid on the 2nd edge, then one per cycle
    cyc(0, 1, 0, 0);
    chk("first_edge_valid", 32'(instr_valid), 32'h0);
    chk("first_edge_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0);
      chk("stream_pc_if", pc_if, 32'(i));
      chk("stream_instr", instr, 32'h100 + 32'(i));
    end
    cyc(0, 1, 0, 0);
    chk("addr_5", imem_addr, 32'h5);

    // Memory wait states on address 5
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h5);
      chk("wait_bubble", 32'(instr_valid), 32'h0);
    end
    cyc(0, 1, 0, 0);
    chk("after_wait_pc_if", pc_if, 32'h5);
    cyc(0, 1, 0, 0);

    // Stall during transfer of 7: buffered, outputs frozen
    cyc(1, 1, 0, 0);
    chk("full_req", 32'(imem_req), 32'h0);
    chk("full_frozen_pc_if", pc_if, 32'h6);
    cyc(1, 1, 0, 0);
    chk("full_hold_pc_if", pc_if, 32'h6);
    cyc(0, 1, 0, 0);
    chk("skid_pc_if", pc_if, 32'h7);
    cyc(0, 1, 0, 0);
    chk("after_skid_pc_if", pc_if, 32'h8);

    // Branch to 0x40 while waiting on 9
    cyc(0, 0, 1, 32'h40);
    chk("pend_addr_held", imem_addr, 32'h9);
    chk("pend_bubble", 32'(instr_valid), 32'h0);
    cyc(0, 1, 0, 0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_drop", 32'(instr_valid), 32'h0);
    cyc(0, 1, 0, 0);
    chk("redir_pc_if", pc_if, 32'h40);

    // Branch to 0x80 while buffered and stalled
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 32'h80);
    chk("full_br_valid", 32'(instr_valid), 32'h0);
    chk("full_br_req", 32'(imem_req), 32'h0);
    cyc(0, 1, 0, 0);
    chk("full_br_addr", imem_addr, 32'h80);
    cyc(0, 1, 0, 0);
    chk("full_br_pc_if", pc_if, 32'h80);

    // Two branches while pending: latest target wins
    cyc(0, 0, 1, 32'h200);
    cyc(0, 0, 1, 32'h300);
    cyc(0, 1, 0, 0);
    chk("latest_wins_addr", imem_addr, 32'h300);
    cyc(0, 1, 0, 0);
    chk("latest_wins_pc_if", pc_if, 32'h300);

    // PC wraps at the top of the address space
    cyc(0, 1, 1, 32'hFFFF_FFFF);
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc_if", pc_if, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_rst_addr", imem_addr, 32'h1);

    // Reset with a request outstanding
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    reset = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      cyc($urandom_range(9) < 3, $urandom_range(9) < 6, $urandom_range(9) == 0,
          ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 1, SHALL be the PC increment per accepted instruction; memory is word-addressed.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on posedge clock.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 stall  input  1  SHALL mean the downstream IF/ID register cannot accept a new instruction this cycle.
REQ-006 branch_taken  input  1  SHALL mean a one-cycle redirect request.
REQ-007 branch_target  input  32  SHALL be the redirect address, sampled when branch_taken=1.
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  32  SHALL be the read address; stable while imem_req=1 and imem_ready=0.
REQ-010 imem_ready  input  1  SHALL mean imem_rdata is valid; a transfer completes on a posedge with imem_req=1 and imem_ready=1.
REQ-011 imem_rdata  input  32  SHALL be the instruction word.
REQ-012 instr  output  32  SHALL be the registered instruction fed to the IF/ID buffer.
REQ-013 pc_if  output  32  SHALL be the registered address of instr.
REQ-014 instr_valid  output  1  SHALL mark instr/pc_if as a real instruction; 0 is a bubble.

Function
REQ-015 FSM states SHALL be IDLE (imem_req=0), REQ (imem_req=1, imem_addr=pc), FULL (one-entry skid holds a fetched word, imem_req=0).
REQ-016 IDLE: stall=0 -> REQ; stall=1 -> IDLE.
REQ-017 REQ without transfer: SHALL stay REQ regardless of stall; stall=0 -> instr_valid<=0.
REQ-018 REQ with transfer, no flush, stall=0: instr<=imem_rdata, pc_if<=pc, instr_valid<=1, pc<=pc+PC_STEP, stay REQ (one instruction per cycle sustained).
REQ-019 REQ with transfer, no flush, stall=1: word and pc SHALL be written to skid, pc<=pc+PC_STEP, next FULL; output registers unchanged.
REQ-020 FULL: stall=0 -> output registers<=skid, instr_valid<=1, next REQ; stall=1 -> hold everything.
REQ-021 stall=1 SHALL freeze instr, pc_if, instr_valid in every state except on flush.
REQ-022 Flush = branch_taken=1 or redirect_pending=1; on flush SHALL force instr_valid<=0 at the same edge, overriding stall.
REQ-023 branch_taken in IDLE or FULL: pc<=branch_target, skid discarded, next REQ if stall=0 else IDLE.
REQ-024 branch_taken in REQ with transfer same edge: returned word discarded, pc<=branch_target, stay REQ.
REQ-025 branch_taken in REQ without transfer: redirect_pending<=1, redirect_pc<=branch_target; imem_addr SHALL NOT change.
REQ-026 Transfer while redirect_pending=1: word discarded, pc<=redirect_pc, redirect_pending<=0, stay REQ.
REQ-027 Second branch_taken while pending: redirect_pc SHALL be overwritten (latest wins).
REQ-028 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFF+1 wraps to 0.
REQ-029 Priority SHALL be reset > branch_taken/redirect > stall.

Reset
REQ-030 On reset=1 at a posedge: state<=IDLE, pc<=RESET_PC, instr<=0, pc_if<=0, instr_valid<=0, skid cleared, redirect_pending<=0, redirect_pc<=0.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; imem_req=0 the cycle after the reset edge.
REQ-032 First instr_valid=1 SHALL appear at the 2nd posedge after reset deasserts when stall=0 and imem_ready=1.

Verification
REQ-033 Reset, then stall=0, imem_ready=1, rdata=addr+0x100 -> instr_valid rises at 2nd edge; pc_if 0,1,2,3 on consecutive cycles; instr 0x100,0x101,...
REQ-034 imem_ready low 3 cycles at addr 5 -> imem_addr stays 5, three bubbles out, then pc_if=5.
REQ-035 stall=1 while transfer of addr 7 completes -> FULL, outputs frozen at pc_if=6; stall=0 -> pc_if=7 next edge, then fetch 8.
REQ-036 branch_taken, target 0x40, while waiting on addr 9 -> word 9 discarded, instr_valid=0, next imem_addr=0x40, pc_if=0x40 after its transfer.
REQ-037 branch_taken with target 0x80 in FULL with stall=1 -> skid dropped, instr_valid=0, IDLE; stall=0 -> fetch 0x80.
REQ-038 pc=32'hFFFF_FFFF, PC_STEP=1, transfer -> next imem_addr=0; reset asserted during REQ -> pc=RESET_PC, imem_req=0.
